// File: rtl/balanca_display_pkg.sv
// Shared constants for the scale display scanner: page codes and 7-segment patterns.
// All segment patterns are active-low {g,f,e,d,c,b,a}.
package balanca_display_pkg;

    localparam logic [1:0] PG_PESO  = 2'd0;
    localparam logic [1:0] PG_PRECO = 2'd1;
    localparam logic [1:0] PG_PKG   = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Element 0 is the rightmost entry: digits 9 down to 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes show a minus sign.
module bcd_to_seg
    import balanca_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_MINUS;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG_TABLE[i_bcd];
        end
    end

endmodule

// File: rtl/balanca_display_scan.sv
// Multiplexed 8-digit display driver for the scale results, one page (int.dec) at a time.
// Data is snapshotted only at frame boundaries; outputs are registered one clock behind the scan state.
module balanca_display_scan
    import balanca_display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int PAGE_HOLD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Peso_Final_unidades,
    input  logic [15:0] Peso_Final_decimal,
    input  logic [15:0] Preco_Parte_Inteira,
    input  logic [15:0] Preco_Parte_Decimal,
    input  logic [15:0] Preco_Por_Kg_Parte_Inteira,
    input  logic [15:0] Preco_Por_Kg_Parte_Decimal,
    input  logic        update,
    input  logic        page_btn,
    input  logic        auto_rotate,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  page
);

    localparam int SCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FCW = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [FCW-1:0] HOLD_LAST = FCW'(PAGE_HOLD - 1);

    logic [SCW-1:0] r_scan_cnt;
    logic [2:0]     r_idx;
    logic [FCW-1:0] r_frame_cnt;
    logic [31:0]    r_snap;
    logic           r_pending;
    logic [1:0]     r_page;
    logic           r_btn_prev;
    logic [7:0]     r_an;
    logic [6:0]     r_seg;
    logic           r_dp;

    logic           w_slot_end;
    logic           w_boundary;
    logic           w_btn_edge;
    logic           w_expire;
    logic           w_advance;
    logic           w_capture;
    logic [31:0]    w_page_words;
    logic [3:0]     w_nibble;
    logic [15:0]    w_int_above;
    logic           w_lead_blank;
    logic [6:0]     w_digit_seg;
    logic [7:0]     w_an_next;
    logic [6:0]     w_seg_next;
    logic           w_dp_next;

    assign w_slot_end = (r_scan_cnt == SCAN_LAST);
    assign w_boundary = w_slot_end && (r_idx == 3'd7);
    assign w_btn_edge = page_btn && !r_btn_prev;
    assign w_expire   = auto_rotate && w_boundary && (r_frame_cnt == HOLD_LAST);
    assign w_advance  = w_btn_edge || w_expire;
    // An update coinciding with the boundary is taken directly, so pending never lingers for it.
    assign w_capture  = w_boundary && (r_pending || update);

    always_comb begin
        w_page_words = {Peso_Final_unidades, Peso_Final_decimal};
        case (r_page)
            PG_PRECO: w_page_words = {Preco_Parte_Inteira, Preco_Parte_Decimal};
            PG_PKG:   w_page_words = {Preco_Por_Kg_Parte_Inteira, Preco_Por_Kg_Parte_Decimal};
            default:  w_page_words = {Peso_Final_unidades, Peso_Final_decimal};
        endcase
    end

    assign w_nibble    = r_snap[{r_idx, 2'b00} +: 4];
    // Integer digits from the current one upward; all-zero means a leading zero on digits 7..5.
    assign w_int_above = r_snap[31:16] >> {r_idx[1:0], 2'b00};
    assign w_lead_blank = r_idx[2] && (r_idx[1:0] != 2'd0) && (w_int_above == 16'd0);

    bcd_to_seg u_bcd_to_seg (
        .i_bcd (w_nibble),
        .o_seg (w_digit_seg)
    );

    assign w_an_next  = (r_scan_cnt == '0) ? 8'hFF : ~(8'd1 << r_idx);
    assign w_seg_next = w_lead_blank ? SEG_BLANK : w_digit_seg;
    assign w_dp_next  = !((r_scan_cnt != '0) && (r_idx == 3'd4));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_idx       <= 3'd0;
            r_frame_cnt <= '0;
            r_snap      <= 32'd0;
            r_pending   <= 1'b1;
            r_page      <= PG_PESO;
            r_btn_prev  <= 1'b0;
            r_an        <= 8'hFF;
            r_seg       <= SEG_BLANK;
            r_dp        <= 1'b1;
        end else begin
            r_btn_prev <= page_btn;
            r_an       <= w_an_next;
            r_seg      <= w_seg_next;
            r_dp       <= w_dp_next;

            if (w_slot_end) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCW'(1);
            end

            if (w_capture) begin
                r_snap <= w_page_words;
            end

            if (w_advance) begin
                r_pending <= 1'b1;
            end else if (w_capture) begin
                r_pending <= 1'b0;
            end else if (update) begin
                r_pending <= 1'b1;
            end

            if (w_advance) begin
                r_page <= (r_page == PG_PKG) ? PG_PESO : r_page + 2'd1;
            end

            if (!auto_rotate || w_advance) begin
                r_frame_cnt <= '0;
            end else if (w_boundary) begin
                r_frame_cnt <= r_frame_cnt + FCW'(1);
            end
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp   = r_dp;
    assign page = r_page;

endmodule

// File: doc/balanca_display_scan.md
Name: balanca_display_scan

Overview:
- Downstream stage of the scale core. Consumes the six 16-bit BCD result words (weight, price, price per kg; integer and decimal part of each) and drives a multiplexed 8-digit common-anode 7-segment display.
- One page is shown at a time: integer part on digits 7..4, decimal point after digit 4, decimal part on digits 3..0.
- Inputs are snapshotted at frame boundaries so a displayed value never tears mid-scan.

Parameters:
- SCAN_DIV, 50000, clocks per digit slot (minimum 2).
- PAGE_HOLD, 1000, complete 8-digit frames per page in auto-rotate mode (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- Peso_Final_unidades  in  16  weight integer part, 4 BCD digits.
- Peso_Final_decimal  in  16  weight decimal part, 4 BCD digits.
- Preco_Parte_Inteira  in  16  price integer part, 4 BCD digits.
- Preco_Parte_Decimal  in  16  price decimal part, 4 BCD digits.
- Preco_Por_Kg_Parte_Inteira  in  16  price/kg integer part, 4 BCD digits.
- Preco_Por_Kg_Parte_Decimal  in  16  price/kg decimal part, 4 BCD digits.
- update  in  1  single-cycle pulse: new results valid.
- page_btn  in  1  synchronized, debounced level; a rising edge advances the page.
- auto_rotate  in  1  high: page advances every PAGE_HOLD frames.
- an  out  8  digit enables, active-low; bit 7 is leftmost.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- page  out  2  current page: 0 = weight, 1 = price, 2 = price/kg.

Behaviour:
- Reset:
  - Outputs: an=8'hFF, seg=7'h7F, dp=1, page=0.
  - Internal state: digit index=0, scan counter=0, frame counter=0, snapshot=0, pending=1 (so the first frame loads live data).
- Scan timing:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→…→7→0.
  - Index wrap 7→0 is the frame boundary.
- Outputs are registered:
  - an/seg/dp reflect the new index one clock after the index changes.
  - In the first clock of every slot (scan counter==0), an=8'hFF for anti-ghosting. Exactly one an bit is low for the remaining SCAN_DIV-1 clocks.
- Snapshot:
  - update=1 sets pending.
  - At a frame boundary with pending=1, the integer/decimal words of the current page are captured into the 32-bit snapshot, and pending is cleared.
  - update arriving in the same cycle as the boundary is captured at that boundary and leaves pending=0.
  - Live inputs never drive segments directly.
- Page control:
  - A page_btn rising edge (registered previous level) advances page 0→1→2→0 immediately, sets pending, and clears the frame counter.
  - With auto_rotate=1, the frame counter increments per frame. On reaching PAGE_HOLD it clears, the page advances, and pending is set.
  - A button edge and auto expiry in the same cycle advance the page by exactly one.
  - auto_rotate=0 holds the frame counter at 0.
- Digit content:
  - Snapshot nibble per index; index i uses bits [4i+3:4i] of {int, dec}.
  - Decoding is via the standard 0–9 table. A nibble >9 shows minus (seg=7'h3F, g only).
- Leading-zero blanking:
  - Digits 7..5 blank (seg=7'h7F) while they and every higher integer digit are 0.
  - Digit 4 is always shown.
  - Decimal digits are never blanked.
- dp=0 only while digit 4 is enabled; otherwise 1.
- rst mid-scan returns everything to reset values on the next edge; no partial frame completes.

Decomposition:
- Package balanca_display_pkg:
  - page encoding constants PG_PESO=0, PG_PRECO=1, PG_PKG=2;
  - SEG_BLANK=7'h7F, SEG_MINUS=7'h3F;
  - the digit-to-segment constant table.
- One combinational sub-module, bcd_to_seg, maps 4-bit BCD to 7-bit active-low segments.
- Counters, snapshot, page control and output registers live in the top.

Test Plan (SCAN_DIV=4, PAGE_HOLD=2):
- Reset held 3 cycles, then released → an=FF, seg=7F, dp=1, page=0 during reset. First frame shows the weight words sampled at the first boundary.
- Weight int=16'h0001, dec=16'h5000 → over one frame: digits 7..5 blank, digit 4 seg=7'h79 ("1") with dp=0, digit 3 "5" (7'h12), digits 2..0 "0" (7'h40).
- Change inputs mid-frame without update, then pulse update mid-frame → old snapshot held to the frame end; new value from the next frame only.
- Price int=16'h0007, dec=16'h0500, page_btn edge → page=1 immediately. The next frame shows 0007.0500 with digits 7..5 blanked.
- auto_rotate=1 → page 0→1→2→0 every 2 frames. A page_btn edge coinciding with expiry advances by exactly one page.
- Nibble 4'hA in weight decimal digit 2 → that slot shows seg=7'h3F. Asserting rst mid-slot gives an=FF next cycle.
